reg_bus_master_bridge: RTL and testbench

- Wishbone classic slave to reg-bus initiator bridge.
- Drives the reg_cs/reg_wr/reg_addr/reg_wdata/reg_be request interface and waits for reg_ack/reg_rdata from peripheral config blocks such as the global config register file.
- Holds one outstanding transfer at a time. A timeout protects the Wishbone side from a non-responding target.
- Sits between the Wishbone interconnect and the pinmux/config register space.

---
 rtl/reg_bus_master_bridge.sv | 155 +++++++++++++++
 tb/tb_reg_bus_master_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_master_bridge.sv
// Wishbone classic slave to reg-bus initiator bridge.
// One outstanding transfer, with a cycle timeout guarding against silent targets.
module reg_bus_master_bridge #(
   parameter int AW         = 8,
   parameter int TMO_CYCLES = 255
) (
   input  logic          mclk,
   input  logic          reset,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [AW-1:0] wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   input  logic [3:0]    wbs_sel_i,
   output logic [31:0]   wbs_dat_o,
   output logic          wbs_ack_o,
   output logic          wbs_err_o,
   output logic          reg_cs,
   output logic          reg_wr,
   output logic [7:0]    reg_addr,
   output logic [31:0]   reg_wdata,
   output logic [3:0]    reg_be,
   input  logic [31:0]   reg_rdata,
   input  logic          reg_ack,
   input  logic          tmo_clr,
   output logic          tmo_flag
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

   state_t      state_q, state_d;
   logic        cs_q, cs_d;
   logic        wr_q, wr_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] dat_q, dat_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic        abort_q, abort_d;
   logic        tmo_flag_q, tmo_flag_d;
   logic        tmo_set;

   always_comb begin
      state_d    = state_q;
      cs_d       = cs_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      dat_d      = dat_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      cnt_d      = cnt_q;
      abort_d    = abort_q;
      tmo_set    = 1'b0;

      case (state_q)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               cs_d    = 1'b1;
               wr_d    = wbs_we_i;
               addr_d  = wbs_adr_i[7:0];
               wdata_d = wbs_dat_i;
               be_d    = wbs_sel_i;
               cnt_d   = 16'd0;
               abort_d = 1'b0;
               state_d = REQ;
            end
         end
         REQ: begin
            // A master that walked away still lets the reg-bus side finish, silently.
            abort_d = abort_q | ~wbs_cyc_i;
            if (reg_ack) begin
               cs_d    = 1'b0;
               state_d = RESP;
               if (!abort_d) begin
                  ack_d = 1'b1;
                  if (!wr_q) begin
                     dat_d = reg_rdata;
                  end
               end
            end else if (cnt_q == TMO_LAST) begin
               cs_d    = 1'b0;
               tmo_set = 1'b1;
               state_d = RESP;
               if (!abort_d) begin
                  err_d = 1'b1;
                  dat_d = 32'd0;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (tmo_set) begin
         tmo_flag_d = 1'b1;
      end else if (tmo_clr) begin
         tmo_flag_d = 1'b0;
      end else begin
         tmo_flag_d = tmo_flag_q;
      end
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cs_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= 8'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         dat_q      <= 32'd0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= 16'd0;
         abort_q    <= 1'b0;
         tmo_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cs_q       <= cs_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         dat_q      <= dat_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         abort_q    <= abort_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

   assign reg_cs    = cs_q;
   assign reg_wr    = wr_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_be    = be_q;
   assign wbs_dat_o = dat_q;
   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;
   assign tmo_flag  = tmo_flag_q;

endmodule

// File: tb/tb_reg_bus_master_bridge.sv
// Directed, table-driven bench for reg_bus_master_bridge with a 4-cycle timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_reg_bus_master_bridge;

   logic        mclk;
   logic        reset;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [7:0]  wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
   logic        wbs_err_o;
   logic        reg_cs;
   logic        reg_wr;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata;
   logic        reg_ack;
   logic        tmo_clr;
   logic        tmo_flag;

   int n_checks = 0;
   int n_fail   = 0;

   reg_bus_master_bridge #(.AW(8), .TMO_CYCLES(4)) dut (
      .mclk      (mclk),
      .reset     (reset),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_dat_o (wbs_dat_o),
      .wbs_ack_o (wbs_ack_o),
      .wbs_err_o (wbs_err_o),
      .reg_cs    (reg_cs),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_be    (reg_be),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack),
      .tmo_clr   (tmo_clr),
      .tmo_flag  (tmo_flag)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // ack_at counts reg_cs cycles from 1; 0 means the target never answers.
   typedef struct {
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          ack_at;
      logic [31:0] rdata;
      logic        abort;
      logic        clr;
      int          exp_cs;
      logic        exp_ack;
      logic        exp_err;
      logic [31:0] exp_dat;
      logic        exp_tmo;
   } txn_t;

   txn_t vec [12];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One Wishbone transfer with a scripted target; counts reg_cs cycles and response pulses.
   task automatic applyStimulus(input int idx);
      txn_t t;
      int   cs_cycles;
      int   ack_pulses;
      int   err_pulses;
      int   guard;
      logic done;
      logic [31:0] dat_seen;
      logic tmo_seen;
      t          = vec[idx];
      cs_cycles  = 0;
      ack_pulses = 0;
      err_pulses = 0;
      done       = 1'b0;
      dat_seen   = 32'd0;
      tmo_seen   = 1'b0;
      @(negedge mclk);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = t.we;
      wbs_adr_i = t.adr;
      wbs_dat_i = t.dat;
      wbs_sel_i = t.sel;
      reg_rdata = t.rdata;
      tmo_clr   = t.clr;
      guard     = 0;
      while (!done && guard < 40) begin
         @(negedge mclk);
         guard++;
         if (wbs_ack_o) ack_pulses++;
         if (wbs_err_o) err_pulses++;
         if (reg_cs) begin
            cs_cycles++;
            checkOutput($sformatf("v%0d_reg_wr", idx), {31'd0, reg_wr}, {31'd0, t.we});
            checkOutput($sformatf("v%0d_reg_addr", idx), {24'd0, reg_addr}, {24'd0, t.adr});
            checkOutput($sformatf("v%0d_reg_wdata", idx), reg_wdata, t.dat);
            checkOutput($sformatf("v%0d_reg_be", idx), {28'd0, reg_be}, {28'd0, t.sel});
            if (t.abort && cs_cycles == 1) begin
               wbs_cyc_i = 1'b0;
               wbs_stb_i = 1'b0;
            end
            reg_ack = (cs_cycles == t.ack_at);
         end else begin
            reg_ack = 1'b0;
            if (cs_cycles > 0) begin
               done      = 1'b1;
               dat_seen  = wbs_dat_o;
               tmo_seen  = tmo_flag;
               wbs_cyc_i = 1'b0;
               wbs_stb_i = 1'b0;
            end
         end
      end
      checkOutput($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      reg_ack   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge mclk);
         if (wbs_ack_o) ack_pulses++;
         if (wbs_err_o) err_pulses++;
         checkOutput($sformatf("v%0d_cs_idle", idx), {31'd0, reg_cs}, 32'd0);
      end
      tmo_clr = 1'b0;
      checkOutput($sformatf("v%0d_cs_cycles", idx), cs_cycles, t.exp_cs);
      checkOutput($sformatf("v%0d_ack_pulses", idx), ack_pulses, {31'd0, t.exp_ack});
      checkOutput($sformatf("v%0d_err_pulses", idx), err_pulses, {31'd0, t.exp_err});
      checkOutput($sformatf("v%0d_dat_o", idx), dat_seen, t.exp_dat);
      checkOutput($sformatf("v%0d_tmo_flag", idx), {31'd0, tmo_seen}, {31'd0, t.exp_tmo});
   endtask

   initial begin
      //            we    adr     dat           sel   ack rdata         abt   clr   cs ack   err   exp_dat       tmo
      vec[0]  = '{1'b1, 8'h08, 32'h1234_5678, 4'hF, 3, 32'h0,        1'b0, 1'b0, 3, 1'b1, 1'b0, 32'h0,        1'b0};
      vec[1]  = '{1'b0, 8'h0C, 32'h0,         4'hF, 1, 32'hA5A5_0003, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'hA5A5_0003, 1'b0};
      vec[2]  = '{1'b1, 8'h10, 32'hDEAD_BEEF, 4'h3, 2, 32'h0,        1'b0, 1'b0, 2, 1'b1, 1'b0, 32'hA5A5_0003, 1'b0};
      vec[3]  = '{1'b0, 8'hFC, 32'h0,         4'hF, 4, 32'h0BAD_F00D, 1'b0, 1'b0, 4, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0};
      vec[4]  = '{1'b1, 8'h44, 32'hCAFE_F00D, 4'hC, 2, 32'h0,        1'b1, 1'b0, 2, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0};
      vec[5]  = '{1'b0, 8'h20, 32'h0,         4'hF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4, 1'b0, 1'b1, 32'h0,        1'b1};
      vec[6]  = '{1'b1, 8'h50, 32'h1111_2222, 4'h1, 0, 32'h0,        1'b1, 1'b0, 4, 1'b0, 1'b0, 32'h0,        1'b1};
      vec[7]  = '{1'b0, 8'h24, 32'h0,         4'hF, 0, 32'h0,        1'b0, 1'b1, 4, 1'b0, 1'b1, 32'h0,        1'b1};
      vec[8]  = '{1'b1, 8'h30, 32'h00FF_00FF, 4'h5, 1, 32'h0,        1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h0,        1'b0};
      vec[9]  = '{1'b0, 8'h04, 32'h0,         4'hF, 2, 32'h0000_0001, 1'b0, 1'b0, 2, 1'b1, 1'b0, 32'h0000_0001, 1'b0};
      vec[10] = '{1'b0, 8'h28, 32'h0,         4'hF, 0, 32'h0,        1'b0, 1'b0, 4, 1'b0, 1'b1, 32'h0,        1'b1};
      vec[11] = '{1'b0, 8'h74, 32'h0,         4'hF, 2, 32'h5EED_5EED, 1'b0, 1'b0, 2, 1'b1, 1'b0, 32'h5EED_5EED, 1'b0};

      reset     = 1'b1;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 8'h00;
      wbs_dat_i = 32'h0;
      wbs_sel_i = 4'h0;
      reg_rdata = 32'h0;
      reg_ack   = 1'b0;
      tmo_clr   = 1'b0;

      #12;
      checkOutput("rst_reg_cs", {31'd0, reg_cs}, 32'd0);
      checkOutput("rst_ack_err", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
      checkOutput("rst_dat_o", wbs_dat_o, 32'd0);
      checkOutput("rst_tmo_flag", {31'd0, tmo_flag}, 32'd0);
      @(negedge mclk);
      reset = 1'b0;
      @(negedge mclk);

      for (int i = 0; i <= 5; i++) applyStimulus(i);

      // Sticky flag survives idle cycles and a single tmo_clr pulse clears it.
      @(negedge mclk);
      checkOutput("tmo_sticky", {31'd0, tmo_flag}, 32'd1);
      tmo_clr = 1'b1;
      @(negedge mclk);
      tmo_clr = 1'b0;
      checkOutput("tmo_cleared", {31'd0, tmo_flag}, 32'd0);

      for (int i = 6; i <= 10; i++) applyStimulus(i);

      // Back-to-back reads with strobe held: second reg_cs two edges after the first ack.
      @(negedge mclk);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 8'h60;
      reg_rdata = 32'h600D_0001;
      @(negedge mclk);
      checkOutput("b2b_cs1", {31'd0, reg_cs}, 32'd1);
      reg_ack = 1'b1;
      @(negedge mclk);
      reg_ack = 1'b0;
      checkOutput("b2b_ack1", {31'd0, wbs_ack_o}, 32'd1);
      checkOutput("b2b_dat1", wbs_dat_o, 32'h600D_0001);
      checkOutput("b2b_gap_cs", {31'd0, reg_cs}, 32'd0);
      @(negedge mclk);
      checkOutput("b2b_resp_cs", {31'd0, reg_cs}, 32'd0);
      checkOutput("b2b_ack_single", {31'd0, wbs_ack_o}, 32'd0);
      reg_rdata = 32'h600D_0002;
      @(negedge mclk);
      checkOutput("b2b_cs2", {31'd0, reg_cs}, 32'd1);
      reg_ack = 1'b1;
      @(negedge mclk);
      reg_ack   = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      checkOutput("b2b_ack2", {31'd0, wbs_ack_o}, 32'd1);
      checkOutput("b2b_dat2", wbs_dat_o, 32'h600D_0002);
      @(negedge mclk);
      @(negedge mclk);
      checkOutput("b2b_end_cs", {31'd0, reg_cs}, 32'd0);

      // Timeout to leave the flag set, then reset in the middle of a request.
      applyStimulus(10);
      @(negedge mclk);
      checkOutput("pre_reset_tmo", {31'd0, tmo_flag}, 32'd1);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 8'h70;
      @(negedge mclk);
      checkOutput("pre_reset_cs", {31'd0, reg_cs}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_reset_cs", {31'd0, reg_cs}, 32'd0);
      checkOutput("mid_reset_ack", {31'd0, wbs_ack_o}, 32'd0);
      checkOutput("mid_reset_tmo", {31'd0, tmo_flag}, 32'd0);
      checkOutput("mid_reset_addr", {24'd0, reg_addr}, 32'd0);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge mclk);
      @(negedge mclk);
      reset = 1'b0;
      @(negedge mclk);
      checkOutput("post_reset_cs", {31'd0, reg_cs}, 32'd0);
      applyStimulus(11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
